// File: rtl/gate_vector_checker.sv
// Self-running stimulus/checker for a two-input gate block: drives the four (a,b) vectors,
// compares the seven gate results against the truth table and reports pass/err status.
module gate_vector_checker #(
   parameter int SETTLE_CYCLES = 1,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   input  logic [6:0]       res_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [1:0]       first_err_vec,
   output logic [6:0]       first_err_bits
);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [SW-1:0] SET_LOAD  = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

   typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, CHECK, DONE} state_t;

   state_t        state;
   logic [1:0]    vec_idx;
   logic [LW-1:0] loop;
   logic [SW-1:0] settle_cnt;
   logic [6:0]    expected;
   logic [6:0]    diff;
   logic [1:0]    nxt_idx;
   logic          last_vec;

   // vec_idx bit0 drives a, bit1 drives b, giving the order 00,10,01,11
   always_comb begin
      expected = 7'h62;
      case (vec_idx)
         2'd0:    expected = 7'h1B;
         2'd1:    expected = 7'h34;
         2'd2:    expected = 7'h35;
         default: expected = 7'h62;
      endcase
      diff = '0;
      for (int i = 0; i < 7; i++) begin
         diff[i] = (res_i[i] !== expected[i]);
      end
      nxt_idx  = vec_idx + 2'd1;
      last_vec = (vec_idx == 2'd3) && (loop == LOOP_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         vec_idx        <= '0;
         loop           <= '0;
         settle_cnt     <= '0;
         a_o            <= 1'b0;
         b_o            <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_cnt        <= '0;
         first_err_vec  <= '0;
         first_err_bits <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state          <= DRIVE;
                  busy           <= 1'b1;
                  err_cnt        <= '0;
                  first_err_vec  <= '0;
                  first_err_bits <= '0;
                  pass           <= 1'b0;
                  vec_idx        <= '0;
                  loop           <= '0;
                  a_o            <= 1'b0;
                  b_o            <= 1'b0;
               end
            end
            DRIVE: begin
               if (SETTLE_CYCLES > 0) begin
                  state      <= SETTLE;
                  settle_cnt <= SET_LOAD;
               end else begin
                  state <= CHECK;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) state <= CHECK;
               else settle_cnt <= settle_cnt - SW'(1);
            end
            CHECK: begin
               if (diff != '0) begin
                  if (!(&err_cnt)) err_cnt <= err_cnt + ERR_W'(1);
                  // a saturating counter never returns to zero, so zero means no earlier mismatch
                  if (err_cnt == '0) begin
                     first_err_vec  <= {a_o, b_o};
                     first_err_bits <= diff;
                  end
               end
               if (last_vec) begin
                  state <= DONE;
                  a_o   <= 1'b0;
                  b_o   <= 1'b0;
               end else begin
                  state   <= DRIVE;
                  vec_idx <= nxt_idx;
                  if (vec_idx == 2'd3) loop <= loop + LW'(1);
                  a_o     <= nxt_idx[0];
                  b_o     <= nxt_idx[1];
               end
            end
            DONE: begin
               done  <= 1'b1;
               pass  <= (err_cnt == '0);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_vector_checker.sv
// Bench for gate_vector_checker: a gate model with per-vector fault masks feeds two checker instances.
`timescale 1ns/1ps
module tb_gate_vector_checker;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;
   logic start_a = 1'b0, start_b = 1'b0;
   logic a_a, b_a, busy_a, done_a, pass_a;
   logic [7:0] err_a;
   logic [1:0] fev_a;
   logic [6:0] feb_a, res_a;
   logic a_b, b_b, busy_b, done_b, pass_b;
   logic [1:0] err_b;
   logic [1:0] fev_b;
   logic [6:0] feb_b, res_b;

   logic [6:0] corr [4];
   logic [1:0] seq [4];
   logic [1:0] obs_ab [64];
   logic       obs_busy [64];
   int done_cyc;
   int compared = 0, mismatched = 0;

   function automatic logic [6:0] golden(input logic a, input logic b);
      return {a & b, a | b, ~(a & b), ~(a | b), a ^ b, ~(a ^ b), ~a};
   endfunction

   always_comb res_a = golden(a_a, b_a) ^ corr[{a_a, b_a}];
   always_comb res_b = golden(a_b, b_b) ^ corr[{a_b, b_b}];

   gate_vector_checker u_a (
      .clk(clk), .rst(rst), .start(start_a), .a_o(a_a), .b_o(b_a), .res_i(res_a),
      .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
      .first_err_vec(fev_a), .first_err_bits(feb_a));

   gate_vector_checker #(.SETTLE_CYCLES(1), .LOOPS(2), .ERR_W(2)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .a_o(a_b), .b_o(b_b), .res_i(res_b),
      .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
      .first_err_vec(fev_b), .first_err_bits(feb_b));

   // Reference: walk the vector list LOOPS times, count faulty vectors, remember the first one.
   task automatic model(input int loops, input int errw, output int e,
                        output logic [1:0] fv, output logic [6:0] fb);
      int n = 0;
      fv = 2'b00;
      fb = 7'h00;
      for (int l = 0; l < loops; l++)
         for (int i = 0; i < 4; i++)
            if (corr[seq[i]] != 7'h00) begin
               if (n == 0) begin
                  fv = seq[i];
                  fb = corr[seq[i]];
               end
               n++;
            end
      e = (n > (1 << errw) - 1) ? (1 << errw) - 1 : n;
   endtask

   function automatic logic [1:0] exp_ab(input int k, input int loops);
      if (k < 12 * loops) return seq[(k / 3) % 4];
      return 2'b00;
   endfunction

   task automatic fill_corr(input int m);
      for (int v = 0; v < 4; v++) begin
         case (m)
            0:       corr[v] = 7'h00;
            1:       corr[v] = golden(v[1], v[0]);
            2:       corr[v] = (v == 3) ? 7'h04 : 7'h00;
            default: corr[v] = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'h00;
         endcase
      end
   endtask

   task automatic do_run(input int sel);
      done_cyc = -1;
      @(negedge clk);
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
      for (int k = 0; k < 60; k++) begin
         obs_ab[k]   = (sel == 0) ? {a_a, b_a} : {a_b, b_b};
         obs_busy[k] = (sel == 0) ? busy_a : busy_b;
         if (((sel == 0) ? done_a : done_b) === 1'b1) begin
            done_cyc = k;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      #2;
      compared++;
      if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fev_a, feb_a} !== '0) begin
         mismatched++;
         $display("FAIL reset_a: outputs %h, want 0", {a_a, b_a, busy_a, done_a, pass_a, err_a, fev_a, feb_a});
      end
      compared++;
      if ({a_b, b_b, busy_b, done_b, pass_b, err_b, fev_b, feb_b} !== '0) begin
         mismatched++;
         $display("FAIL reset_b: outputs %h, want 0", {a_b, b_b, busy_b, done_b, pass_b, err_b, fev_b, feb_b});
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // modes: 0 golden, 1 res tied to zero, 2 xor flipped at a=b=1, then random fault masks
   task automatic test_patterns();
      int e, bad;
      logic [1:0] fv;
      logic [6:0] fb;
      for (int m = 0; m < 10; m++) begin
         fill_corr(m);
         model(1, 8, e, fv, fb);
         do_run(0);
         compared++;
         if (done_cyc != 13) begin
            mismatched++;
            $display("FAIL patt%0d_done_cycle: got %0d, want 13", m, done_cyc);
         end
         bad = 0;
         for (int k = 0; k < 13; k++)
            if (obs_ab[k] !== exp_ab(k, 1) || obs_busy[k] !== 1'b1) bad++;
         compared++;
         if (bad != 0) begin
            mismatched++;
            $display("FAIL patt%0d_sequence: %0d bad cycles, want 0", m, bad);
         end
         compared++;
         if (err_a !== 8'(e) || pass_a !== (e == 0) || busy_a !== 1'b0) begin
            mismatched++;
            $display("FAIL patt%0d_status: err %0d pass %b busy %b, want err %0d pass %b busy 0",
                     m, err_a, pass_a, busy_a, e, (e == 0));
         end
         compared++;
         if (fev_a !== fv || feb_a !== fb) begin
            mismatched++;
            $display("FAIL patt%0d_first_err: vec %b bits %h, want vec %b bits %h", m, fev_a, feb_a, fv, fb);
         end
         @(posedge clk); #1;
         compared++;
         if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            mismatched++;
            $display("FAIL patt%0d_done_pulse: done %b busy %b, want 0 0", m, done_a, busy_a);
         end
      end
   endtask

   task automatic test_saturate();
      int e, bad;
      logic [1:0] fv;
      logic [6:0] fb;
      for (int m = 1; m < 5; m++) begin
         fill_corr(m);
         model(2, 2, e, fv, fb);
         do_run(1);
         compared++;
         if (done_cyc != 25) begin
            mismatched++;
            $display("FAIL sat%0d_done_cycle: got %0d, want 25", m, done_cyc);
         end
         bad = 0;
         for (int k = 0; k < 25; k++)
            if (obs_ab[k] !== exp_ab(k, 2) || obs_busy[k] !== 1'b1) bad++;
         compared++;
         if (bad != 0) begin
            mismatched++;
            $display("FAIL sat%0d_sequence: %0d bad cycles, want 0", m, bad);
         end
         compared++;
         if (err_b !== 2'(e) || pass_b !== (e == 0) || fev_b !== fv || feb_b !== fb) begin
            mismatched++;
            $display("FAIL sat%0d_status: err %0d pass %b vec %b bits %h, want err %0d pass %b vec %b bits %h",
                     m, err_b, pass_b, fev_b, feb_b, e, (e == 0), fv, fb);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_rst_mid_run();
      int seen_done = 0;
      fill_corr(0);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(posedge clk); #1;
      end
      compared++;
      if ({a_a, b_a} !== 2'b01 || busy_a !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_pre: ab %b busy %b, want 01 1", {a_a, b_a}, busy_a);
      end
      rst = 1'b1;
      #1;
      compared++;
      if ({a_a, b_a, busy_a, done_a, pass_a, err_a, fev_a, feb_a} !== '0) begin
         mismatched++;
         $display("FAIL rst_mid_outputs: %h, want 0", {a_a, b_a, busy_a, done_a, pass_a, err_a, fev_a, feb_a});
      end
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done_a !== 1'b0 || busy_a !== 1'b0 || {a_a, b_a} !== 2'b00) seen_done++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (done_a !== 1'b0) seen_done++;
      end
      compared++;
      if (seen_done != 0) begin
         mismatched++;
         $display("FAIL rst_no_done: %0d bad cycles, want 0", seen_done);
      end
      do_run(0);
      compared++;
      if (done_cyc != 13 || pass_a !== 1'b1 || err_a !== 8'd0) begin
         mismatched++;
         $display("FAIL rst_rerun: done %0d pass %b err %0d, want 13 1 0", done_cyc, pass_a, err_a);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int ndone = 0, d1 = -1, d2 = -1;
      fill_corr(1);
      @(negedge clk);
      start_a = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 40; k++) begin
         if (k == 3) start_a = 1'b0;
         if (k == 5) start_a = 1'b1;
         if (done_a === 1'b1) begin
            ndone++;
            if (ndone == 1) d1 = k;
            else if (ndone == 2) d2 = k;
         end
         if (k == 13) begin
            compared++;
            if (err_a !== 8'd4 || pass_a !== 1'b0 || busy_a !== 1'b0) begin
               mismatched++;
               $display("FAIL b2b_run1: err %0d pass %b busy %b, want 4 0 0", err_a, pass_a, busy_a);
            end
            fill_corr(0);
         end
         if (k == 14) begin
            compared++;
            if (busy_a !== 1'b1 || {a_a, b_a} !== 2'b00 || err_a !== 8'd0 || done_a !== 1'b0) begin
               mismatched++;
               $display("FAIL b2b_restart: busy %b ab %b err %0d done %b, want 1 00 0 0",
                        busy_a, {a_a, b_a}, err_a, done_a);
            end
         end
         if (k == 27) begin
            compared++;
            if (pass_a !== 1'b1 || err_a !== 8'd0) begin
               mismatched++;
               $display("FAIL b2b_run2: pass %b err %0d, want 1 0", pass_a, err_a);
            end
            start_a = 1'b0;
         end
         @(posedge clk); #1;
      end
      compared++;
      if (ndone != 2 || d1 != 13 || d2 != 27) begin
         mismatched++;
         $display("FAIL b2b_done_cycles: count %0d at %0d,%0d, want 2 at 13,27", ndone, d1, d2);
      end
   endtask

   initial begin
      for (int v = 0; v < 4; v++) corr[v] = 7'h00;
      seq[0] = 2'b00;
      seq[1] = 2'b10;
      seq[2] = 2'b01;
      seq[3] = 2'b11;
      test_reset();
      test_patterns();
      test_saturate();
      test_rst_mid_run();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
